// File: rtl/stopwatch_disp_scan.sv
// Multiplexed 6-digit common-anode 7-segment driver for the stopwatch BCD digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero minute digits.
module stopwatch_disp_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] mh,
  input  logic [3:0] ml,
  input  logic [3:0] sh,
  input  logic [3:0] sl,
  input  logic [3:0] msh,
  input  logic [3:0] msl,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  logic [CW-1:0] div_cnt_r;
  logic [2:0]    idx_r;
  logic [3:0]    shd_mh_r, shd_ml_r, shd_sh_r, shd_sl_r, shd_msh_r, shd_msl_r;
  logic          tick_s;
  logic [3:0]    digit_s;
  logic [5:0]    an_s;
  logic [6:0]    seg_s;
  logic          dp_s;
  logic          blank_s;

  assign tick_s = (div_cnt_r == DIV_MAX);

  // Per-digit dwell counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end
  end

  // Scan index and frame-boundary snapshot; shadow loads together with the wrap to digit 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      idx_r     <= 3'd0;
      shd_mh_r  <= 4'd0;
      shd_ml_r  <= 4'd0;
      shd_sh_r  <= 4'd0;
      shd_sl_r  <= 4'd0;
      shd_msh_r <= 4'd0;
      shd_msl_r <= 4'd0;
    end else if (idx_r > 3'd5) begin
      idx_r <= 3'd0;
    end else if (tick_s && (idx_r == 3'd5)) begin
      idx_r     <= 3'd0;
      shd_mh_r  <= mh;
      shd_ml_r  <= ml;
      shd_sh_r  <= sh;
      shd_sl_r  <= sl;
      shd_msh_r <= msh;
      shd_msl_r <= msl;
    end else if (tick_s) begin
      idx_r <= idx_r + 3'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Digit and anode selection for the current scan position.
  always_comb begin
    digit_s = 4'd0;
    an_s    = 6'h3F;
    case (idx_r)
      3'd0: begin digit_s = shd_msl_r; an_s = 6'b111110; end
      3'd1: begin digit_s = shd_msh_r; an_s = 6'b111101; end
      3'd2: begin digit_s = shd_sl_r;  an_s = 6'b111011; end
      3'd3: begin digit_s = shd_sh_r;  an_s = 6'b110111; end
      3'd4: begin digit_s = shd_ml_r;  an_s = 6'b101111; end
      3'd5: begin digit_s = shd_mh_r;  an_s = 6'b011111; end
      default: begin digit_s = 4'd0; an_s = 6'h3F; end
    endcase
    if (!en) begin
      an_s = 6'h3F;
    end else begin
      an_s = an_s;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading zero suppression on the minutes digits.
  always_comb begin
    blank_s = 1'b0;
    case (idx_r)
      3'd5:    blank_s = (shd_mh_r == 4'd0);
      3'd4:    blank_s = (shd_mh_r == 4'd0) && (shd_ml_r == 4'd0);
      default: blank_s = 1'b0;
    endcase
  end
`else
  assign blank_s = 1'b0;
`endif

  // Segment and decimal-point values; dp marks mm.ss.cc separators.
  always_comb begin
    seg_s = ~seg_decode(digit_s);
    dp_s  = ((idx_r == 3'd2) || (idx_r == 3'd4)) ? 1'b0 : 1'b1;
    if (blank_s || (idx_r > 3'd5)) begin
      seg_s = 7'h7F;
      dp_s  = 1'b1;
    end else begin
      seg_s = seg_s;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (clr) begin
      an  <= 6'h3F;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_s;
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_stopwatch_disp_scan.sv
// Randomized self-checking bench for stopwatch_disp_scan (SCAN_DIV=4 and SCAN_DIV=1 instances).
module tb_stopwatch_disp_scan;

  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] din [6];
  logic [5:0] an, an1;
  logic [6:0] seg, seg1;
  logic       dp, dp1;

  int checks = 0;
  int errors = 0;

  // reference model state: elapsed cycles since clear and frame shadows
  int         el4, el1, cur4;
  logic [3:0] sh4 [6];
  logic [3:0] sh1 [6];
  logic [13:0] exp4, exp1;

  always #5 clk = ~clk;

  stopwatch_disp_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .clr(clr), .en(en),
    .mh(din[5]), .ml(din[4]), .sh(din[3]), .sl(din[2]), .msh(din[1]), .msl(din[0]),
    .an(an), .seg(seg), .dp(dp)
  );

  stopwatch_disp_scan #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .clr(clr), .en(en),
    .mh(din[5]), .ml(din[4]), .sh(din[3]), .sl(din[2]), .msh(din[1]), .msl(din[0]),
    .an(an1), .seg(seg1), .dp(dp1)
  );

  function automatic logic [13:0] model_out(input int idx, input logic [3:0] shd [6], input logic en_v);
    logic [5:0] a;
    logic [6:0] s;
    logic       d;
    a = en_v ? (6'h3F ^ (6'd1 << idx)) : 6'h3F;
    s = SEG_TBL[shd[idx]];
    d = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
    if (BLANK && ((idx == 5 && shd[5] == 4'd0) || (idx == 4 && shd[5] == 4'd0 && shd[4] == 4'd0))) begin
      s = 7'h7F;
      d = 1'b1;
    end
    return {a, s, d};
  endfunction

  // one clock: update model from the inputs seen at this edge, then settle
  task automatic step();
    @(posedge clk);
    if (clr) begin
      el4 = 0; el1 = 0; cur4 = -1;
      for (int i = 0; i < 6; i++) begin sh4[i] = 4'd0; sh1[i] = 4'd0; end
      exp4 = {6'h3F, 7'h7F, 1'b1};
      exp1 = {6'h3F, 7'h7F, 1'b1};
    end else begin
      cur4 = (el4 / 4) % 6;
      exp4 = model_out(cur4, sh4, en);
      if (el4 % 24 == 23) sh4 = din;
      el4++;
      exp1 = model_out(el1 % 6, sh1, en);
      if (el1 % 6 == 5) sh1 = din;
      el1++;
    end
    #1;
  endtask

  task automatic test_reset();
    int run, nchg;
    logic [5:0] prev;
    clr = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) din[i] = 4'd0;
    step(); step();
    checks++;
    if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
      errors++; $display("FAIL reset_state an=%b seg=%h dp=%b expected an=111111 seg=7f dp=1", an, seg, dp);
    end
    clr = 1'b0;
    step();
    checks++;
    if (an !== 6'b111110 || seg !== 7'h40 || dp !== 1'b1) begin
      errors++; $display("FAIL first_digit an=%b seg=%h dp=%b expected an=111110 seg=40 dp=1", an, seg, dp);
    end
    run = 1; nchg = 0; prev = an;
    for (int k = 0; k < 24; k++) begin
      step();
      checks++;
      if ({an, seg, dp} !== exp4) begin
        errors++; $display("FAIL reset_frame an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", an, seg, dp, exp4[13:8], exp4[7:1], exp4[0]);
      end
      if (an != prev) begin
        nchg++;
        checks++;
        if (run !== 4) begin errors++; $display("FAIL dwell an=%b lit %0d cycles expected 4", prev, run); end
        run = 1;
      end else run++;
      prev = an;
    end
    checks++;
    if (nchg !== 6 || an !== 6'b111110) begin
      errors++; $display("FAIL frame_len changes=%0d an=%b expected 6 changes and an=111110 after 24 cycles", nchg, an);
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] snap_seg [6];
    int guard;
    snap_seg = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 6; k++) step();
    din = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    guard = 0;
    step();
    while (cur4 != 0 && guard < 40) begin
      checks++;
      if (seg !== ((BLANK && cur4 >= 4) ? 7'h7F : 7'h40)) begin
        errors++; $display("FAIL snap_hold idx=%0d seg=%h expected old zero frame", cur4, seg);
      end
      step(); guard++;
    end
    checks++;
    if (guard >= 40) begin errors++; $display("FAIL snap_timeout guard=%0d expected < 40", guard); end
    for (int k = 0; k < 24; k++) begin
      if (k != 0) step();
      checks++;
      if (seg !== snap_seg[cur4] || dp !== ((cur4 == 2 || cur4 == 4) ? 1'b0 : 1'b1) || {an, seg, dp} !== exp4) begin
        errors++; $display("FAIL snap_frame idx=%0d seg=%h dp=%b expected seg=%h", cur4, seg, dp, snap_seg[cur4]);
      end
    end
  endtask

  task automatic test_invalid();
    int nf, p;
    din[3] = 4'hC;
    nf = 0; p = cur4;
    for (int k = 0; k < 80; k++) begin
      step();
      if (cur4 == 0 && p != 0) nf++;
      p = cur4;
      if (nf == 2 && cur4 == 3) break;
    end
    checks++;
    if (cur4 !== 3 || seg !== 7'h3F || dp !== 1'b1) begin
      errors++; $display("FAIL invalid_dash idx=%0d seg=%h dp=%b expected idx 3 seg=3f dp=1", cur4, seg, dp);
    end
  endtask

  task automatic test_enable();
    for (int k = 0; k < 9; k++) step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (an !== 6'h3F || {an, seg, dp} !== exp4) begin
        errors++; $display("FAIL en_off an=%b seg=%h dp=%b expected an=111111 seg=%h", an, seg, dp, exp4[7:1]);
      end
    end
    en = 1'b1;
    step();
    for (int k = 0; k < 30; k++) begin
      step();
      checks++;
      if ({an, seg, dp} !== exp4 || {an1, seg1, dp1} !== exp1) begin
        errors++; $display("FAIL en_resume an=%b an1=%b expected %b %b", an, an1, exp4[13:8], exp1[13:8]);
      end
    end
  endtask

  task automatic test_mid_clear();
    int guard;
    guard = 0;
    while (cur4 != 3 && guard < 30) begin step(); guard++; end
    clr = 1'b1;
    step();
    checks++;
    if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
      errors++; $display("FAIL clr_mid an=%b seg=%h dp=%b expected an=111111 seg=7f dp=1", an, seg, dp);
    end
    clr = 1'b0;
    step();
    checks++;
    if (an !== 6'b111110 || seg !== 7'h40 || dp !== 1'b1) begin
      errors++; $display("FAIL clr_restart an=%b seg=%h dp=%b expected an=111110 seg=40 dp=1", an, seg, dp);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (an1 !== (6'h3F ^ (6'd1 << (k % 6)))) begin
        errors++; $display("FAIL div1_rotate k=%0d an1=%b expected %b", k, an1, 6'h3F ^ (6'd1 << (k % 6)));
      end
      step();
    end
  endtask

  task automatic test_blank();
    logic [6:0] e5, e4;
    logic       d4;
    for (int pass = 0; pass < 2; pass++) begin
      din = '{4'd1, 4'd2, 4'd3, 4'd4, (pass == 0) ? 4'd0 : 4'd7, 4'd0};
      for (int k = 0; k < 48; k++) step();
      while (cur4 != 4) step();
      e4 = (pass == 0) ? (BLANK ? 7'h7F : 7'h40) : 7'h78;
      d4 = (pass == 0 && BLANK) ? 1'b1 : 1'b0;
      checks++;
      if (seg !== e4 || dp !== d4) begin
        errors++; $display("FAIL blank_d4 pass=%0d seg=%h dp=%b expected seg=%h dp=%b", pass, seg, dp, e4, d4);
      end
      for (int k = 0; k < 4; k++) step();
      e5 = BLANK ? 7'h7F : 7'h40;
      checks++;
      if (an !== 6'b011111 || seg !== e5 || dp !== 1'b1) begin
        errors++; $display("FAIL blank_d5 pass=%0d an=%b seg=%h dp=%b expected an=011111 seg=%h dp=1", pass, an, seg, dp, e5);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 6; i++) din[i] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 15) din[5] = 4'd0;
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 99) < 2);
      step();
      checks++;
      if ({an, seg, dp} !== exp4 || {an1, seg1, dp1} !== exp1) begin
        errors++; $display("FAIL random k=%0d dut=%b/%h/%b exp=%b/%h/%b dut1=%b/%h/%b exp1=%b/%h/%b", k,
                           an, seg, dp, exp4[13:8], exp4[7:1], exp4[0], an1, seg1, dp1, exp1[13:8], exp1[7:1], exp1[0]);
      end
    end
    clr = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_invalid();
    test_enable();
    test_mid_clear();
    test_blank();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
